// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, hazard stall, flush and optional
// two-entry skid buffer so ready_o never depends combinationally on ready_i.
module pipe_stage #(
  parameter int unsigned          DATA_W      = 96,
  parameter int unsigned          CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
  parameter bit                   SKID        = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [CTRL_W-1:0]   head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                rdy_en_q;

  logic head_vld, skid_vld, acc, cons;

  assign head_vld = (state_q != StEmpty);
  assign skid_vld = (state_q == StTwo);

  // rdy_en_q keeps ready_o low while in reset and until the first edge after release.
  always_comb begin
    ready_o = 1'b0;
    if (rdy_en_q && !stall_i) begin
      if (SKID) begin
        ready_o = ~skid_vld;
      end else begin
        ready_o = ~head_vld | ready_i;
      end
    end
  end

  assign acc     = valid_i & ready_o;
  assign cons    = head_vld & ready_i & ~stall_i;
  assign valid_o = head_vld;
  assign ctrl_o  = head_vld ? head_ctrl_q : CTRL_BUBBLE;
  assign data_o  = head_data_q;
  assign occ_o   = {1'b0, head_vld} + {1'b0, skid_vld};

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      // Only the valid state is cleared; payload registers keep their contents.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (acc && cons) begin
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
          end else if (acc && SKID) begin
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
            state_d     = StTwo;
          end else if (cons) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (cons) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning payload width in bits (e.g. RS data, RT data, immediate).
REQ-002 The block SHALL have parameter CTRL_W, default 8, meaning control-field width in bits (e.g. RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite).
REQ-003 The block SHALL have parameter CTRL_BUBBLE, default all-zero, meaning the control value presented for a bubble (no side effects).
REQ-004 The block SHALL have parameter SKID, default 1, meaning 1 selects 2-entry skid buffering and 0 selects a single entry.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port valid_i, input, 1 bit: the upstream stage presents an instruction.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the stage accepts an instruction this cycle.
REQ-009 The block SHALL have port ctrl_i, input, CTRL_W bits: incoming control fields.
REQ-010 The block SHALL have port data_i, input, DATA_W bits: incoming payload.
REQ-011 The block SHALL have port stall_i, input, 1 bit: hazard stall that freezes the stage.
REQ-012 The block SHALL have port flush_i, input, 1 bit: squash all held instructions.
REQ-013 The block SHALL have port valid_o, output, 1 bit: the head entry is valid.
REQ-014 The block SHALL have port ready_i, input, 1 bit: the downstream stage accepts.
REQ-015 The block SHALL have port ctrl_o, output, CTRL_W bits: head control, or CTRL_BUBBLE when valid_o=0.
REQ-016 The block SHALL have port data_o, output, DATA_W bits: head payload.
REQ-017 The block SHALL have port occ_o, output, 2 bits: number of held entries (0..2).

Function
REQ-018 Acceptance SHALL occur when valid_i & ready_o; consumption SHALL occur when valid_o & ready_i & ~stall_i.
REQ-019 Storage SHALL comprise a head register, plus a skid register when SKID=1; outputs SHALL always come from the head register.
REQ-020 With SKID=1, the state SHALL be one of EMPTY (occ 0), ONE (head valid) or TWO (head and skid valid).
REQ-021 With SKID=1, ready_o SHALL equal ~skid_valid & ~stall_i, driven only from registers and stall_i, with no path from ready_i.
REQ-022 With SKID=0, ready_o SHALL equal (~head_valid | ready_i) & ~stall_i, and the TWO state SHALL be unreachable.
REQ-023 EMPTY + accept SHALL move to ONE with the head loaded; latency SHALL be 1 cycle from accept to valid_o.
REQ-024 ONE + accept + consume SHALL stay in ONE with the head reloaded from the input.
REQ-025 ONE + accept + no consume SHALL move to TWO, with the input written to the skid register (SKID=1 only).
REQ-026 ONE + consume + no accept SHALL move to EMPTY.
REQ-027 In TWO + consume, the skid register SHALL move to the head and the state SHALL move to ONE; there SHALL be no accept, because ready_o=0.
REQ-028 Order SHALL be preserved: no entry overtakes another, and none is dropped or duplicated except by flush.
REQ-029 stall_i=1 SHALL freeze all state; there SHALL be no accept and no consume, and valid_o, ctrl_o and data_o SHALL hold.
REQ-030 flush_i=1 SHALL clear both valid bits at the next edge, giving occ 0 and ctrl_o=CTRL_BUBBLE.
REQ-031 flush_i SHALL take priority over stall_i and over a simultaneous accept; the accepted input SHALL be discarded.
REQ-032 When an entry is invalidated, its data registers SHALL keep their last value; only the valid bits and ctrl gating SHALL change.
REQ-033 ctrl_o SHALL be gated combinationally to CTRL_BUBBLE whenever valid_o=0.
REQ-034 occ_o SHALL equal head_valid + skid_valid at all times.

Reset
REQ-035 While rst_n_i=0, asynchronously: valid_o=0, occ_o=0, ctrl_o=CTRL_BUBBLE, data_o=0, and the skid register SHALL be cleared.
REQ-036 ready_o SHALL be 0 during reset and SHALL equal ~stall_i from the first edge after deassertion.
REQ-037 Reset asserted mid-operation (any state) SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-038 Streaming: SKID=1, ready_i=1, data_i=1..8 on consecutive cycles -> data_o=1..8 one cycle later, occ_o=1 throughout, ready_o=1.
REQ-039 Backpressure: accept A, then hold ready_i=0 while offering B and C -> occ_o goes 1, 2; ready_o=0 in TWO; C is not accepted; raising ready_i yields A then B.
REQ-040 Stall: in ONE with data_o=0x55, stall_i=1 for 3 cycles with valid_i=1 and ready_i=1 -> ready_o=0, data_o=0x55 and occ_o=1 hold; the stream resumes in order.
REQ-041 Flush: in TWO, assert flush_i together with stall_i and valid_i -> next cycle valid_o=0, occ_o=0, ctrl_o=CTRL_BUBBLE; the input is dropped.
REQ-042 SKID=0: with ready_i=0 and a held entry, ready_o=0 and occ_o never exceeds 1; ready_i=1 with valid_i=1 gives back-to-back transfers.
REQ-043 Async reset: drop rst_n_i mid-cycle in TWO -> valid_o=0 and occ_o=0 before the next edge; after release ready_o=1 and the first accepted word appears 1 cycle later.
